// File: rtl/alu_divu_ctrl.sv
// DIVU sequencer: borrows the shared ALU for WIDTH cycles to run a restoring
// shift-subtract division, leaving the quotient in lo and the remainder in hi.
module alu_divu_ctrl #(
    parameter int          WIDTH    = 32,
    parameter logic [5:0]  SIG_SUB  = 6'd34,
    parameter logic [5:0]  SIG_DIVU = 6'd27
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       signal_in,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             alu_own,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [5:0]       alu_signal,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem, quo, dvsr;
    logic [WIDTH-1:0] t, rem_n, quo_n;
    logic             accept, take, last;

    assign accept = (state == S_IDLE) && start && (signal_in == SIG_DIVU);
    assign last   = (count == CW'(WIDTH - 1));

    // rem[WIDTH-1] acts as the carried-out 33rd bit of t: when set, t exceeds
    // any divisor so the subtract is always taken.
    assign t     = {rem[WIDTH-2:0], quo[WIDTH-1]};
    assign take  = rem[WIDTH-1] | alu_cout;
    assign rem_n = take ? alu_result : t;
    assign quo_n = {quo[WIDTH-2:0], take};

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (accept) state_n = (divisor == '0) ? S_DONE : S_DIV;
            S_DIV:   if (last) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        alu_own    = (state == S_DIV);
        alu_signal = alu_own ? SIG_SUB : 6'd0;
        alu_a      = alu_own ? t : '0;
        alu_b      = alu_own ? dvsr : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            rem   <= '0;
            quo   <= '0;
            dvsr  <= '0;
            hi    <= '0;
            lo    <= '0;
            dz    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    if (divisor == '0) begin
                        dz <= 1'b1;
                        lo <= '1;
                        hi <= dividend;
                    end else begin
                        dvsr  <= divisor;
                        quo   <= dividend;
                        rem   <= '0;
                        count <= '0;
                    end
                end
                S_DIV: begin
                    rem   <= rem_n;
                    quo   <= quo_n;
                    count <= count + 1'b1;
                    if (last) begin
                        hi <= rem_n;
                        lo <= quo_n;
                        dz <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_divu_ctrl.sv
// Randomized scoreboard bench for alu_divu_ctrl; a behavioural ALU sits beside
// the DUT and expected results come from plain integer division.
module tb_alu_divu_ctrl;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  signal_in = 6'd0;
    logic [31:0] dividend = '0, divisor = '0;
    logic        busy, done, dz, alu_own, alu_cout;
    logic [31:0] hi, lo, alu_a, alu_b, alu_result;
    logic [5:0]  alu_signal;

    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];
    exp_t last_e = '0;

    alu_divu_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .signal_in(signal_in),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .dz(dz), .hi(hi), .lo(lo), .alu_own(alu_own), .alu_a(alu_a),
        .alu_b(alu_b), .alu_signal(alu_signal), .alu_result(alu_result),
        .alu_cout(alu_cout)
    );

    // shared ALU, subtract only
    assign alu_result = alu_a - alu_b;
    assign alu_cout   = (alu_a >= alu_b);

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        if (b == 0) begin
            e.lo = 32'hFFFF_FFFF; e.hi = a; e.dz = 1'b1;
        end else begin
            e.lo = a / b; e.hi = a % b; e.dz = 1'b0;
        end
        return e;
    endfunction

    // monitor: pops the scoreboard whenever done is presented
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (alu_own) chk("alu_signal_div", {58'd0, alu_signal}, 64'd34);
            else         chk("alu_signal_idle", {58'd0, alu_signal}, 64'd0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious_done actual=1 expected=0 t=%0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("lo", {32'd0, lo}, {32'd0, e.lo});
                    chk("hi", {32'd0, hi}, {32'd0, e.hi});
                    chk("dz", {63'd0, dz}, {63'd0, e.dz});
                end
            end
        end
    end

    // inj: cycle at which a second start (new operands) is driven while busy
    // rst_at: cycle at which reset is pulsed mid-operation
    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [5:0] sig,
                       input int inj, input int rst_at);
        exp_t e;
        bit   acc, seen;
        int   n, nbusy, nown, lim;
        acc = (sig == 6'd27);
        e   = model(a, b);
        lim = acc ? 60 : 5;
        @(posedge clk); #1;
        start = 1'b1; signal_in = sig; dividend = a; divisor = b;
        if (acc && rst_at < 0) exp_q.push_back(e);
        n = 0; nbusy = 0; nown = 0; seen = 1'b0;
        while (!seen && n < lim) begin
            @(posedge clk); #1;
            n++;
            start = 1'b0; signal_in = 6'($urandom);
            dividend = $urandom; divisor = $urandom;
            if (n == inj) begin start = 1'b1; signal_in = 6'd27; end
            if (rst_at >= 0 && n == rst_at + 1) begin
                chk("rst_busy", {63'd0, busy}, 64'd0);
                chk("rst_done", {63'd0, done}, 64'd0);
                chk("rst_own", {63'd0, alu_own}, 64'd0);
                chk("rst_hilo", {hi, lo}, 64'd0);
                chk("rst_dz", {63'd0, dz}, 64'd0);
                exp_q.delete();
                reset = 1'b0;
                last_e = '0;
                break;
            end
            if (rst_at >= 0 && n == rst_at) reset = 1'b1;
            if (busy) nbusy++;
            if (alu_own) nown++;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        if (rst_at >= 0) begin
            nbusy = 0; seen = 1'b0;
            repeat (40) begin
                @(posedge clk); #1;
                if (busy) nbusy++;
                if (done) seen = 1'b1;
            end
            chk("no_done_after_rst", {63'd0, seen}, 64'd0);
            chk("idle_after_rst", nbusy, 0);
        end else if (!acc) begin
            chk("ignored_busy", nbusy, 0);
            chk("ignored_done", {63'd0, seen}, 64'd0);
            chk("ignored_hold", {hi, lo}, {last_e.hi, last_e.lo});
        end else begin
            if (!seen) begin
                total++; bad++;
                $display("FAIL timeout actual=no_done expected=done a=%h b=%h", a, b);
            end
            chk("latency", n, (b == 0) ? 1 : 33);
            chk("busy_cycles", nbusy, (b == 0) ? 1 : 33);
            chk("own_cycles", nown, (b == 0) ? 0 : 32);
            @(posedge clk); #1;
            start = 1'b0;
            chk("hold_hilo", {hi, lo}, {e.hi, e.lo});
            chk("hold_dz", {63'd0, dz}, {63'd0, e.dz});
            chk("after_done_idle", {62'd0, busy, done}, 64'd0);
            last_e = e;
        end
    endtask

    initial begin
        logic [31:0] a, b;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_dz", {63'd0, dz}, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        chk("reset_own", {63'd0, alu_own}, 64'd0);
        reset = 1'b0;

        run(32'd100, 32'd7, 6'd27, -1, -1);
        run(32'hFFFF_FFFF, 32'd1, 6'd27, -1, -1);
        run(32'hFFFF_FFFF, 32'h8000_0000, 6'd27, -1, -1);
        run(32'd3, 32'd10, 6'd27, -1, -1);
        run(32'd0, 32'd5, 6'd27, -1, -1);
        run(32'd5, 32'd0, 6'd27, -1, -1);
        run(32'd77, 32'd6, 6'd34, -1, -1);
        run(32'd1000, 32'd33, 6'd27, 10, -1);
        run(32'd12345, 32'd0, 6'd27, 1, -1);
        run(32'hDEAD_BEEF, 32'd17, 6'd27, 33, -1);
        run(32'hCAFE_F00D, 32'd99, 6'd27, -1, 15);
        run(32'd9, 32'd3, 6'd27, -1, -1);

        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 100);
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = $urandom | 32'h8000_0000;
                default: b = $urandom;
            endcase
            run(a, b, ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 26)) : 6'd27, -1, -1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        repeat (2) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
